multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the shared datapath: one ALU, one unified memory port, the register file and the immediate extender. It decodes the IR opcode and drives every datapath select and enable, including the extender's sign/zero select. It also runs a ready-handshake with the memory port. It replaces hard-wired single-cycle control when the CPU is built in its multicycle configuration.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multicycle controller and the shared datapath / memory port.
// The controller drives every select and enable and the memory request; the datapath drives opcode, zero and mem_ready.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_op, ext_sel, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_op, ext_sel, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences the shared ALU, unified memory port,
// register file and immediate extender, with a ready handshake on memory accesses.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH      = 4'd1,
        DECODE     = 4'd2,
        MEM_ADDR   = 4'd3,
        MEM_ACCESS = 4'd4,
        MEM_WB     = 4'd5,
        EXEC_R     = 4'd6,
        R_WB       = 4'd7,
        EXEC_I     = 4'd8,
        I_WB       = 4'd9,
        BRANCH     = 4'd10,
        JUMP       = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    logic   isLogicImm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // andi/ori zero-extend their immediate and let the ALU pick the op from the opcode.
    assign isLogicImm = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
    assign bus.state  = state_q;

    always_comb begin
        state_d        = state_q;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.ext_sel    = 1'b1;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = MEM_ADDR;
                    OP_R:                     state_d = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = EXEC_I;
                    OP_BEQ:                   state_d = BRANCH;
                    OP_J:                     state_d = JUMP;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = MEM_ACCESS;
            end
            MEM_ACCESS: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = (bus.opcode == OP_SW);
                if (bus.mem_ready) state_d = (bus.opcode == OP_LW) ? MEM_WB : FETCH;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = FETCH;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = isLogicImm ? 2'b11 : 2'b00;
                bus.ext_sel   = !isLogicImm;
                state_d       = I_WB;
            end
            I_WB: begin
                bus.reg_write = 1'b1;
                bus.ext_sel   = !isLogicImm;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-instruction state traces,
// randomized instruction stream against a trace-building reference model, and reset corner cases.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       iord;
        logic       irWrite;
        logic       pcEn;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       extSel;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       illegal;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        int   st;
        logic rdy;
        logic z;
    } step_t;

    typedef struct {
        logic [5:0]  op;
        int          fw;
        int          mw;
        logic        z;
        int          expLen;
        logic [31:0] expStates;
    } vec_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    step_t       trace[$];
    logic [31:0] actStates;
    int          actLen;
    vec_t        vecs[12];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic obs_t sampleObs();
        obs_t o;
        o.memReq   = bus.mem_req;
        o.memWe    = bus.mem_we;
        o.iord     = bus.iord;
        o.irWrite  = bus.ir_write;
        o.pcEn     = bus.pc_en;
        o.pcSrc    = bus.pc_src;
        o.aluSrcA  = bus.alu_src_a;
        o.aluSrcB  = bus.alu_src_b;
        o.aluOp    = bus.alu_op;
        o.extSel   = bus.ext_sel;
        o.regWrite = bus.reg_write;
        o.regDst   = bus.reg_dst;
        o.memToReg = bus.mem_to_reg;
        o.illegal  = bus.illegal;
        o.state    = bus.state;
        return o;
    endfunction

    // Expected outputs for one cycle: defaults, then the overrides each state lists.
    function automatic obs_t modelObs(int st, logic [5:0] op, logic rdy, logic z);
        obs_t o;
        logic logicImm;
        logicImm = (op == OP_ANDI) || (op == OP_ORI);
        o        = '0;
        o.extSel = 1'b1;
        o.state  = 4'(st);
        case (st)
            1:  begin o.memReq = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcEn = rdy; end
            2:  begin
                    o.aluSrcB = 2'b11;
                    o.illegal = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J});
                end
            3:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            4:  begin o.memReq = 1; o.iord = 1; o.memWe = (op == OP_SW); end
            5:  begin o.regWrite = 1; o.memToReg = 1; end
            6:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
            7:  begin o.regWrite = 1; o.regDst = 1; end
            8:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluOp = logicImm ? 2'b11 : 2'b00; o.extSel = !logicImm; end
            9:  begin o.regWrite = 1; o.extSel = !logicImm; end
            10: begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcSrc = 2'b01; o.pcEn = z; end
            11: begin o.pcSrc = 2'b10; o.pcEn = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic step_t mkStep(int st, logic rdy, logic z);
        step_t s;
        s.st  = st;
        s.rdy = rdy;
        s.z   = z;
        return s;
    endfunction

    // The cycle-by-cycle state walk of one instruction, built from its class and wait counts.
    task automatic buildTrace(input logic [5:0] op, input int fw, input int mw, input logic z);
        trace.delete();
        for (int i = 0; i < fw; i++) trace.push_back(mkStep(1, 1'b0, 1'($urandom_range(0, 1))));
        trace.push_back(mkStep(1, 1'b1, 1'($urandom_range(0, 1))));
        trace.push_back(mkStep(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        if (op == OP_LW || op == OP_SW) begin
            trace.push_back(mkStep(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            for (int i = 0; i < mw; i++) trace.push_back(mkStep(4, 1'b0, 1'($urandom_range(0, 1))));
            trace.push_back(mkStep(4, 1'b1, 1'($urandom_range(0, 1))));
            if (op == OP_LW) trace.push_back(mkStep(5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end else if (op == OP_R) begin
            trace.push_back(mkStep(6, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            trace.push_back(mkStep(7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end else if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
            trace.push_back(mkStep(8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            trace.push_back(mkStep(9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end else if (op == OP_BEQ) begin
            trace.push_back(mkStep(10, 1'($urandom_range(0, 1)), z));
        end else if (op == OP_J) begin
            trace.push_back(mkStep(11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] op, input int fw, input int mw, input logic z);
        obs_t a;
        buildTrace(op, fw, mw, z);
        actStates = '0;
        actLen    = 0;
        foreach (trace[i]) begin
            @(negedge clk);
            if (trace[i].st == 2) bus.opcode = op;
            bus.mem_ready = trace[i].rdy;
            bus.zero      = trace[i].z;
            #2;
            a         = sampleObs();
            actStates = {actStates[27:0], a.state};
            actLen++;
            checkOutput($sformatf("%s op=%b step%0d", tag, op, i), 32'(a),
                        32'(modelObs(trace[i].st, op, trace[i].rdy, trace[i].z)));
        end
    endtask

    initial begin
        logic [5:0] legalOps[8];
        logic [5:0] op;
        obs_t       a;

        legalOps = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
        vecs[0]  = '{OP_R,     0, 0, 1'b0, 4, 32'h0000_1267};
        vecs[1]  = '{OP_LW,    2, 1, 1'b0, 8, 32'h1112_3445};
        vecs[2]  = '{OP_SW,    0, 0, 1'b0, 4, 32'h0000_1234};
        vecs[3]  = '{OP_ORI,   0, 0, 1'b0, 4, 32'h0000_1289};
        vecs[4]  = '{OP_ADDI,  1, 0, 1'b0, 5, 32'h0001_1289};
        vecs[5]  = '{OP_ANDI,  0, 0, 1'b0, 4, 32'h0000_1289};
        vecs[6]  = '{OP_BEQ,   0, 0, 1'b1, 3, 32'h0000_012A};
        vecs[7]  = '{OP_BEQ,   0, 0, 1'b0, 3, 32'h0000_012A};
        vecs[8]  = '{OP_J,     0, 0, 1'b0, 3, 32'h0000_012B};
        vecs[9]  = '{6'b111111, 0, 0, 1'b0, 2, 32'h0000_0012};
        vecs[10] = '{OP_LW,    0, 0, 1'b0, 5, 32'h0001_2345};
        vecs[11] = '{OP_SW,    0, 2, 1'b0, 6, 32'h0012_3444};

        rst_n         = 1'b0;
        bus.opcode    = 6'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checkOutput("reset outputs", 32'(sampleObs()), 32'(modelObs(0, 6'b0, 1'b0, 1'b0)));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("idle after release", 32'(sampleObs()), 32'(modelObs(0, 6'b0, 1'b0, 1'b0)));

        foreach (vecs[v]) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].op, vecs[v].fw, vecs[v].mw, vecs[v].z);
            checkOutput($sformatf("vec%0d state trace", v), actStates, vecs[v].expStates);
            checkOutput($sformatf("vec%0d cycles", v), 32'(actLen), 32'(vecs[v].expLen));
        end

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                if (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J}) op = 6'b111110;
            end else begin
                op = legalOps[$urandom_range(0, 7)];
            end
            applyStimulus($sformatf("rand%0d", n), op, $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while FETCH is waiting on memory.
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        a = sampleObs();
        checkOutput("fetch wait before reset", {a.state, 3'b0, a.memReq}, {4'd1, 3'b0, 1'b1});
        rst_n = 1'b0;
        #1;
        a = sampleObs();
        checkOutput("reset drops mem_req", 32'(a.memReq), 32'd0);
        checkOutput("reset state", 32'(a.state), 32'd0);
        checkOutput("reset ext_sel", 32'(a.extSel), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("idle after mid reset", 32'(sampleObs()), 32'(modelObs(0, 6'b0, 1'b0, 1'b0)));
        @(negedge clk);
        #2;
        checkOutput("fetch after idle", 32'(sampleObs()), 32'(modelObs(1, bus.opcode, 1'b0, bus.zero)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
